// File: rtl/axi_boundary_read_if.sv
// Bundle of upstream request/data and AXI-side address/data signals for axi_boundary_read.
// The slave modport is the block's view; the master modport is the surrounding environment.
interface axi_boundary_read_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_len;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rlast;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_len;
    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast;

    modport master (
        output s_valid, s_addr, s_len, s_rready,
        output m_ready, m_rvalid, m_rdata, m_rlast,
        input  s_ready, s_rvalid, s_rdata, s_rlast,
        input  m_valid, m_addr, m_len, m_rready
    );

    modport slave (
        input  s_valid, s_addr, s_len, s_rready,
        input  m_ready, m_rvalid, m_rdata, m_rlast,
        output s_ready, s_rvalid, s_rdata, s_rlast,
        output m_valid, m_addr, m_len, m_rready
    );
endinterface

// File: rtl/axi_boundary_read.sv
// Splits an upstream read burst at a 4 KB boundary into at most two AXI sub-bursts and
// returns the read data as one stream whose last flag marks the end of the original burst.
module axi_boundary_read #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    axi_boundary_read_if.slave bus
);
    localparam int BEAT_B = DATA_W / 8;
    localparam int OFF_W  = $clog2(BEAT_B);

    typedef enum logic [1:0] {
        IDLE,
        ADDR1,
        ADDR2,
        DATA
    } state_t;

    function automatic logic [12:0] beats_to_boundary(input logic [11:0] page_off);
        logic [12:0] bytes_left;
        bytes_left = 13'd4096 - {1'b0, page_off};
        return bytes_left >> OFF_W;
    endfunction

    state_t            state;
    logic              m_valid_q;
    logic              sub_cnt;
    logic              split_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [7:0]        m_len_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [7:0]        len2_q;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_page;
    logic [12:0]       k_beats;
    logic [12:0]       n_beats;
    logic              split_req;
    logic [7:0]        len1;
    logic [7:0]        len2;

    logic              s_ready_w;
    logic              active;
    logic              accept;
    logic              addr_hs;
    logic              final_hs;
    logic              sub_last;

    // Request decode: beat-aligned start, beats left in the page, and the split geometry.
    assign start_addr = bus.s_addr & ~ADDR_W'(BEAT_B - 1);
    assign k_beats    = beats_to_boundary(start_addr[11:0]);
    assign n_beats    = {5'd0, bus.s_len} + 13'd1;
    assign split_req  = n_beats > k_beats;
    assign len1       = split_req ? 8'(k_beats - 13'd1) : bus.s_len;
    assign len2       = 8'(n_beats - k_beats - 13'd1);
    assign next_page  = {start_addr[ADDR_W-1:12] + (ADDR_W - 12)'(1), 12'h000};

    assign s_ready_w = (state == IDLE) && !rst;
    assign active    = (state != IDLE);
    assign accept    = bus.s_valid && s_ready_w;
    assign addr_hs   = m_valid_q && bus.m_ready;
    assign sub_last  = bus.m_rvalid && bus.m_rready && bus.m_rlast;
    assign final_hs  = bus.s_rvalid && bus.s_rready && bus.s_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_valid_q <= 1'b0;
            sub_cnt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        state     <= ADDR1;
                        m_valid_q <= 1'b1;
                        sub_cnt   <= 1'b0;
                    end
                end
                ADDR1: begin
                    if (addr_hs) begin
                        if (split_q) begin
                            state <= ADDR2;
                        end else begin
                            state     <= DATA;
                            m_valid_q <= 1'b0;
                        end
                    end
                end
                ADDR2: begin
                    if (addr_hs) begin
                        state     <= DATA;
                        m_valid_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (final_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Counts completed sub-bursts; can coincide with the second address handshake.
            if (sub_last) begin
                sub_cnt <= ~sub_cnt;
            end
        end
    end

    // Request payload is latched once and never re-read from the upstream side.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_addr_q <= start_addr;
            m_len_q  <= len1;
            addr2_q  <= next_page;
            len2_q   <= len2;
            split_q  <= split_req;
        end else if (state == ADDR1 && addr_hs) begin
            m_addr_q <= addr2_q;
            m_len_q  <= len2_q;
        end
    end

    assign bus.s_ready  = s_ready_w;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_len    = m_len_q;

    // Zero-latency return path, gated off while no transaction is open.
    assign bus.s_rvalid = active && bus.m_rvalid;
    assign bus.m_rready = active && bus.s_rready;
    assign bus.s_rdata  = bus.m_rdata;
    assign bus.s_rlast  = active && bus.m_rlast && (sub_cnt == split_q);
endmodule

// File: tb/tb_axi_boundary_read.sv
// Bench for axi_boundary_read: vector table of burst geometries with a beat scoreboard,
// plus hand-written backpressure, reset and 128-bit maximum-burst sequences.
module tb_axi_boundary_read;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_boundary_read_if #(.ADDR_W(32), .DATA_W(32))  bus ();
    axi_boundary_read_if #(.ADDR_W(32), .DATA_W(128)) bus128 ();

    axi_boundary_read #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    axi_boundary_read #(.ADDR_W(32), .DATA_W(128)) u_dut128 (
        .clk (clk),
        .rst (rst),
        .bus (bus128)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] a1;
        logic [7:0]  l1;
        logic        split;
        logic [31:0] a2;
        logic [7:0]  l2;
    } vec_t;

    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_data_q[$];
    logic        exp_last_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream-side scoreboard: every beat delivered must match the next expected beat.
    always @(negedge clk) begin
        if (bus.s_rvalid && bus.s_rready) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                logic [31:0] d;
                logic        l;
                d = exp_data_q.pop_front();
                l = exp_last_q.pop_front();
                chk("rdata", bus.s_rdata, d);
                chk("rlast", bus.s_rlast, l);
            end
        end
    end

    task automatic send_req(input logic [31:0] addr, input logic [7:0] len);
        bit got;
        got = 0;
        bus.s_valid = 1'b1;
        bus.s_addr  = addr;
        bus.s_len   = len;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.s_ready;
            step();
        end
        bus.s_valid = 1'b0;
        chk("req_accept", got, 1);
        chk("m_valid_latency", bus.m_valid, 1);
        chk("s_ready_busy", bus.s_ready, 0);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [7:0] l, input int delay);
        chk("m_valid", bus.m_valid, 1);
        chk("m_addr", bus.m_addr, a);
        chk("m_len", bus.m_len, l);
        for (int i = 0; i < delay; i++) begin
            bus.m_ready = 1'b0;
            step();
            chk("hold_m_valid", bus.m_valid, 1);
            chk("hold_m_addr", bus.m_addr, a);
            chk("hold_m_len", bus.m_len, l);
        end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic mlast,
                              input logic slast_exp, input logic with_mready);
        bit hs;
        hs = 0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = data;
        bus.m_rlast  = mlast;
        if (with_mready) bus.m_ready = 1'b1;
        exp_data_q.push_back(data);
        exp_last_q.push_back(slast_exp);
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = bus.m_rready;
            step();
        end
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.m_ready  = 1'b0;
        if (!hs) chk("beat_timeout", 0, 1);
    endtask

    task automatic run_txn(input vec_t v);
        send_req(v.addr, v.len);
        addr_phase(v.a1, v.l1, 0);
        if (v.split) begin
            chk("addr2_valid", bus.m_valid, 1);
            chk("addr2_addr", bus.m_addr, v.a2);
            chk("addr2_len", bus.m_len, v.l2);
            // Last beat of the first sub-burst coincides with the second address handshake.
            for (int b = 0; b <= int'(v.l1); b++)
                drive_beat($urandom, b == int'(v.l1), 1'b0, b == int'(v.l1));
            chk("addr2_done", bus.m_valid, 0);
            chk("s_ready_mid", bus.s_ready, 0);
            for (int b = 0; b <= int'(v.l2); b++)
                drive_beat($urandom, b == int'(v.l2), b == int'(v.l2), 1'b0);
        end else begin
            chk("no_addr2", bus.m_valid, 0);
            for (int b = 0; b <= int'(v.l1); b++)
                drive_beat($urandom, b == int'(v.l1), b == int'(v.l1), 1'b0);
        end
        chk("idle_after", bus.s_ready, 1);
        chk("sb_empty", exp_data_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 8'd15,  32'h0000_0100, 8'd15, 1'b0, 32'h0, 8'd0};
        vecs[1] = '{32'h0000_0FF8, 8'd7,   32'h0000_0FF8, 8'd1,  1'b1, 32'h0000_1000, 8'd5};
        vecs[2] = '{32'h0000_0FC0, 8'd15,  32'h0000_0FC0, 8'd15, 1'b0, 32'h0, 8'd0};
        vecs[3] = '{32'h0000_0000, 8'd3,   32'h0000_0000, 8'd3,  1'b0, 32'h0, 8'd0};
        vecs[4] = '{32'hFFFF_FFFC, 8'd3,   32'hFFFF_FFFC, 8'd0,  1'b1, 32'h0000_0000, 8'd2};
        vecs[5] = '{32'h1234_5FF0, 8'd255, 32'h1234_5FF0, 8'd3,  1'b1, 32'h1234_6000, 8'd251};
        vecs[6] = '{32'h0000_2000, 8'd255, 32'h0000_2000, 8'd255, 1'b0, 32'h0, 8'd0};

        rst = 1'b1;
        bus.s_valid = 0; bus.s_addr = 0; bus.s_len = 0; bus.s_rready = 1'b1;
        bus.m_ready = 0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEAD_BEEF; bus.m_rlast = 1'b1;
        bus128.s_valid = 0; bus128.s_addr = 0; bus128.s_len = 0; bus128.s_rready = 1'b1;
        bus128.m_ready = 0; bus128.m_rvalid = 0; bus128.m_rdata = '0; bus128.m_rlast = 0;
        step();
        step();
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_rvalid", bus.s_rvalid, 0);
        chk("rst_m_rready", bus.m_rready, 0);
        chk("rst_s_rlast", bus.s_rlast, 0);
        step();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", bus.s_ready, 1);
        step();

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Unaligned single beat with address and data backpressure.
        send_req(32'h0000_0FFE, 8'd0);
        addr_phase(32'h0000_0FFC, 8'd0, 3);
        chk("bp_no_addr2", bus.m_valid, 0);
        bus.s_rready = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hCAFE_0001;
        bus.m_rlast  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_m_rready", bus.m_rready, 0);
            chk("bp_s_rvalid", bus.s_rvalid, 1);
            chk("bp_s_rlast", bus.s_rlast, 1);
            step();
        end
        bus.s_rready = 1'b1;
        drive_beat(32'hCAFE_0001, 1'b1, 1'b1, 1'b0);
        chk("bp_idle", bus.s_ready, 1);
        chk("bp_sb_empty", exp_data_q.size(), 0);

        // Reset while the second address is pending.
        send_req(32'h0000_0FF8, 8'd7);
        addr_phase(32'h0000_0FF8, 8'd1, 0);
        chk("mid_in_addr2", bus.m_valid, 1);
        rst = 1'b1;
        step();
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_s_rvalid", bus.s_rvalid, 0);
        chk("mid_rst_m_rready", bus.m_rready, 0);
        step();
        bus.m_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_s_ready", bus.s_ready, 1);
        step();
        run_txn(vecs[3]);

        // 128-bit data path, maximum burst straddling a boundary.
        begin
            bit got;
            logic [127:0] d;
            got = 0;
            bus128.s_valid = 1'b1;
            bus128.s_addr  = 32'h0000_0F00;
            bus128.s_len   = 8'd255;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = bus128.s_ready;
                step();
            end
            bus128.s_valid = 1'b0;
            chk("w128_accept", got, 1);
            chk("w128_m_valid1", bus128.m_valid, 1);
            chk("w128_m_addr1", bus128.m_addr, 32'h0000_0F00);
            chk("w128_m_len1", bus128.m_len, 8'd15);
            bus128.m_ready = 1'b1;
            step();
            bus128.m_ready = 1'b0;
            chk("w128_m_valid2", bus128.m_valid, 1);
            chk("w128_m_addr2", bus128.m_addr, 32'h0000_1000);
            chk("w128_m_len2", bus128.m_len, 8'd239);
            bus128.m_ready = 1'b1;
            step();
            bus128.m_ready = 1'b0;
            chk("w128_addr_done", bus128.m_valid, 0);
            for (int b = 0; b < 256; b++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                bus128.m_rvalid = 1'b1;
                bus128.m_rdata  = d;
                bus128.m_rlast  = (b == 15) || (b == 255);
                @(negedge clk);
                chk("w128_s_rvalid", bus128.s_rvalid, 1);
                chk("w128_s_rdata", bus128.s_rdata, d);
                chk("w128_s_rlast", bus128.s_rlast, b == 255);
                chk("w128_s_ready_busy", bus128.s_ready, 0);
                step();
            end
            bus128.m_rvalid = 1'b0;
            bus128.m_rlast  = 1'b0;
            chk("w128_idle", bus128.s_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
